// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter: NR requesters share one FIFO write port.
// A winner keeps the port for up to BURST beats, then a single idle cycle follows.
module fifo_wr_arb #(
  parameter int NR    = 4,
  parameter int DW    = 16,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [NR-1:0]    req_valid,
  input  logic [NR*DW-1:0] req_data,
  output logic [NR-1:0]    req_ready,
  input  logic             fifo_full,
  output logic             fifo_wren,
  output logic [DW-1:0]    fifo_din,
  output logic [NR-1:0]    grant,
  output logic             busy
);

  localparam int PW = (NR > 1) ? $clog2(NR) : 1;
  localparam int CW = $clog2(BURST + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST_ST = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [NR-1:0]   grant_q, grant_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

  logic [PW-1:0]   pick_idx_s;
  logic [PW-1:0]   low_idx_s;
  logic [PW-1:0]   hi_idx_s;
  logic            hi_found_s;
  logic [PW-1:0]   gidx_s;
  logic [PW-1:0]   next_ptr_s;
  logic            xfer_s;
  logic            last_beat_s;
  logic            owner_valid_s;

  // Handshake toward requesters and FIFO; all gated by the registered grant.
  assign req_ready = grant_q & {NR{en & ~fifo_full}};
  assign xfer_s    = |(req_valid & req_ready);
  assign fifo_wren = xfer_s;
  assign grant     = grant_q;
  assign busy      = (state_q == BURST_ST);

  assign owner_valid_s = |(req_valid & grant_q);
  assign last_beat_s   = xfer_s && (beat_cnt_q == CW'(BURST - 1));

  // Round-robin pick: lowest valid index at or above rr_ptr, else lowest overall.
  always_comb begin
    low_idx_s  = '0;
    hi_idx_s   = '0;
    hi_found_s = 1'b0;
    for (int i = NR - 1; i >= 0; i--) begin
      low_idx_s = req_valid[i] ? PW'(i) : low_idx_s;
      if (req_valid[i] && (i >= int'(rr_ptr_q))) begin
        hi_idx_s   = PW'(i);
        hi_found_s = 1'b1;
      end else begin
        hi_idx_s   = hi_idx_s;
        hi_found_s = hi_found_s;
      end
    end
    pick_idx_s = hi_found_s ? hi_idx_s : low_idx_s;
  end

  // Encode the current owner and steer its data onto the FIFO bus.
  always_comb begin
    gidx_s   = '0;
    fifo_din = '0;
    for (int i = 0; i < NR; i++) begin
      gidx_s   = grant_q[i] ? PW'(i) : gidx_s;
      fifo_din = grant_q[i] ? req_data[i*DW +: DW] : fifo_din;
    end
    if (NR == 1) begin
      next_ptr_s = '0;
    end else if (gidx_s == PW'(NR - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = gidx_s + PW'(1);
    end
  end

  // Next-state logic for the IDLE/BURST controller.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (en && (|req_valid)) begin
          grant_d    = NR'(1'b1) << pick_idx_s;
          beat_cnt_d = '0;
          state_d    = BURST_ST;
        end else begin
          grant_d    = '0;
          state_d    = IDLE;
        end
      end
      BURST_ST: begin
        // A beat taken in the release cycle still lands in the FIFO.
        if (!en || !owner_valid_s || last_beat_s) begin
          grant_d    = '0;
          beat_cnt_d = '0;
          rr_ptr_d   = next_ptr_s;
          state_d    = IDLE;
        end else if (xfer_s) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end
      default: begin
        state_d    = IDLE;
        grant_d    = '0;
        beat_cnt_d = '0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed self-checking bench for fifo_wr_arb (NR=4, DW=16, BURST=4).
module tb_fifo_wr_arb;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wren;
  logic [15:0] fifo_din;
  logic [3:0]  grant;
  logic        busy;

  int checks;
  int failures;

  logic [15:0] words [4] = '{16'h1A00, 16'h2B11, 16'h3C22, 16'h4D33};

  assign req_data = {words[3], words[2], words[1], words[0]};

  fifo_wr_arb #(.NR(4), .DW(16), .BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .fifo_full (fifo_full),
    .fifo_wren (fifo_wren),
    .fifo_din  (fifo_din),
    .grant     (grant),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] din_of(input logic [3:0] g);
    logic [15:0] d;
    d = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) d = words[i];
    end
    return d;
  endfunction

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [3:0] rdy,
                            input logic w, input logic b);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".ready"}, 32'(req_ready), 32'(rdy));
    chk({tag, ".wren"},  32'(fifo_wren), 32'(w));
    chk({tag, ".din"},   32'(fifo_din), 32'(din_of(g)));
    chk({tag, ".busy"},  32'(busy), 32'(b));
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [3:0] g;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    en        = 1'b1;
    req_valid = 4'b1111;
    fifo_full = 1'b0;

    // Reset holds everything at zero even with requests pending.
    #3;
    expect_out("rst0", 4'b0000, 4'b0000, 1'b0, 1'b0);
    next_cyc();
    expect_out("rst1", 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Single requester with 6 words: 4-beat burst, bubble, 2 more words.
    rst_n = 1'b1;
    req_valid = 4'b0001;
    #1;
    expect_out("s1.idle", 4'b0000, 4'b0000, 1'b0, 1'b0);
    for (int b = 0; b < 4; b++) begin
      next_cyc();
      expect_out($sformatf("s1.beat%0d", b), 4'b0001, 4'b0001, 1'b1, 1'b1);
    end
    next_cyc();
    expect_out("s1.bubble", 4'b0000, 4'b0000, 1'b0, 1'b0);
    next_cyc();
    expect_out("s1.beat4", 4'b0001, 4'b0001, 1'b1, 1'b1);
    next_cyc();
    expect_out("s1.beat5", 4'b0001, 4'b0001, 1'b1, 1'b1);
    next_cyc();
    req_valid = 4'b0000;
    #1;
    expect_out("s1.empty", 4'b0001, 4'b0001, 1'b0, 1'b1);
    next_cyc();
    expect_out("s1.rel", 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Round robin from a fresh reset: 0001,0010,0100,1000,0001.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req_valid = 4'b1111;
    #1;
    expect_out("rr.idle", 4'b0000, 4'b0000, 1'b0, 1'b0);
    next_cyc();
    for (int r = 0; r < 5; r++) begin
      g = 4'b0001 << (r % 4);
      for (int b = 0; b < 4; b++) begin
        expect_out($sformatf("rr.g%0d.b%0d", r, b), g, g, 1'b1, 1'b1);
        next_cyc();
      end
      expect_out($sformatf("rr.bubble%0d", r), 4'b0000, 4'b0000, 1'b0, 1'b0);
      next_cyc();
    end

    // Early release: requester 1 drops after one beat; next pick starts at 2.
    expect_out("er.beat0", 4'b0010, 4'b0010, 1'b1, 1'b1);
    next_cyc();
    req_valid = 4'b1001;
    #1;
    expect_out("er.drop", 4'b0010, 4'b0010, 1'b0, 1'b1);
    next_cyc();
    expect_out("er.rel", 4'b0000, 4'b0000, 1'b0, 1'b0);
    next_cyc();
    expect_out("er.regrant", 4'b1000, 4'b1000, 1'b1, 1'b1);

    // en low mid-burst: ready drops at once, grant clears next cycle.
    next_cyc();
    en = 1'b0;
    #1;
    expect_out("en.off", 4'b1000, 4'b0000, 1'b0, 1'b1);
    next_cyc();
    expect_out("en.rel", 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Full stall in a requester-2 burst after two beats.
    en = 1'b1;
    req_valid = 4'b0100;
    #1;
    expect_out("fs.idle", 4'b0000, 4'b0000, 1'b0, 1'b0);
    next_cyc();
    expect_out("fs.beat0", 4'b0100, 4'b0100, 1'b1, 1'b1);
    next_cyc();
    expect_out("fs.beat1", 4'b0100, 4'b0100, 1'b1, 1'b1);
    next_cyc();
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      expect_out($sformatf("fs.stall%0d", k), 4'b0100, 4'b0000, 1'b0, 1'b1);
      next_cyc();
    end
    fifo_full = 1'b0;
    #1;
    expect_out("fs.beat2", 4'b0100, 4'b0100, 1'b1, 1'b1);
    next_cyc();
    expect_out("fs.beat3", 4'b0100, 4'b0100, 1'b1, 1'b1);
    next_cyc();
    expect_out("fs.rel", 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Reset mid-burst: outputs clear asynchronously, restart from index 0.
    req_valid = 4'b1110;
    next_cyc();
    expect_out("mr.grant", 4'b1000, 4'b1000, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("mr.async", 4'b0000, 4'b0000, 1'b0, 1'b0);
    next_cyc();
    expect_out("mr.held", 4'b0000, 4'b0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    expect_out("mr.idle", 4'b0000, 4'b0000, 1'b0, 1'b0);
    next_cyc();
    expect_out("mr.first", 4'b0010, 4'b0010, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
